multicycle_sequencer: RTL and testbench



---
 rtl/multicycle_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the KGP-miniRISC core.
// Optional build macro PERF_CNT_EN adds saturating cycle_cnt/instr_cnt outputs.
module multicycle_sequencer #(
  parameter logic [5:0] HALT_OPCODE = 6'h3F,
  parameter logic [7:0] MEM_TIMEOUT = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [1:0] reg_write,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic [1:0] branch,
  input  logic       zero_flag,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_load,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       alu_en,
  output logic       rf_we,
  output logic [1:0] rf_we_sel,
  output logic       pc_load,
  output logic       pc_sel,
  output logic       busy,
  output logic       halted,
  output logic       fault
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  logic [2:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_hit;
  logic       taken;

  assign timeout_hit = (MEM_TIMEOUT != 8'd0) && (wait_q == (MEM_TIMEOUT - 8'd1));

  always_comb begin
    case (branch)
      2'b01:   taken = 1'b1;
      2'b10:   taken = zero_flag;
      2'b11:   taken = ~zero_flag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_en    = 1'b0;
    rf_we     = 1'b0;
    rf_we_sel = 2'b00;
    pc_load   = 1'b0;
    pc_sel    = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        busy    = 1'b1;
        state_d = (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        busy   = 1'b1;
        // Branch resolution takes priority over any memory or write-back flags.
        if (branch != 2'b00) begin
          pc_load = 1'b1;
          pc_sel  = taken;
          state_d = S_FETCH;
        end else if (mem_read || mem_write) begin
          state_d = S_MEM;
        end else if (reg_write != 2'b00) begin
          state_d = S_WB;
        end else begin
          pc_load = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write;
        busy     = 1'b1;
        if (dmem_ready) begin
          if (mem_read) begin
            state_d = S_WB;
          end else begin
            pc_load = 1'b1;
            state_d = S_FETCH;
          end
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        rf_we_sel = reg_write;
        pc_load   = 1'b1;
        busy      = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: fault  = 1'b1;
    endcase
    // Every wait window starts counting from zero.
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) wait_d = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (busy && (cycle_cnt_q != 32'hFFFF_FFFF))    cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (pc_load && (instr_cnt_q != 32'hFFFF_FFFF)) instr_cnt_d = instr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed tables plus randomized instruction streams
// whose expected per-cycle strobes are generated from instruction-level rules.
module tb_multicycle_sequencer;

  localparam logic [7:0] TO = 8'd4;

  logic       clk = 1'b0;
  logic       rst, start, mem_read, mem_write, zero_flag, imem_ready, dmem_ready;
  logic [5:0] opcode;
  logic [1:0] reg_write, branch;
  logic       imem_req, ir_load, dmem_req, dmem_we, alu_en, rf_we, pc_load, pc_sel;
  logic       busy, halted, fault;
  logic [1:0] rf_we_sel;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_sequencer #(.HALT_OPCODE(6'h3F), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .zero_flag(zero_flag),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_load(ir_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_en(alu_en), .rf_we(rf_we),
    .rf_we_sel(rf_we_sel), .pc_load(pc_load), .pc_sel(pc_sel), .busy(busy),
    .halted(halted), .fault(fault)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  localparam logic [12:0] O_IMEM  = 13'h1000;
  localparam logic [12:0] O_IRL   = 13'h0800;
  localparam logic [12:0] O_DREQ  = 13'h0400;
  localparam logic [12:0] O_DWE   = 13'h0200;
  localparam logic [12:0] O_ALU   = 13'h0100;
  localparam logic [12:0] O_RFWE  = 13'h0080;
  localparam logic [12:0] O_PCL   = 13'h0010;
  localparam logic [12:0] O_PCS   = 13'h0008;
  localparam logic [12:0] O_BUSY  = 13'h0004;
  localparam logic [12:0] O_HALT  = 13'h0002;
  localparam logic [12:0] O_FAULT = 13'h0001;

  logic [12:0] act;
  assign act = {imem_req, ir_load, dmem_req, dmem_we, alu_en, rf_we, rf_we_sel,
                pc_load, pc_sel, busy, halted, fault};

  function automatic logic [12:0] o_sel(input logic [1:0] s);
    return {6'b0, s, 5'b0};
  endfunction

  typedef struct {
    logic        rst;
    logic        start;
    logic [5:0]  op;
    logic [1:0]  rw;
    logic        mr;
    logic        mw;
    logic [1:0]  br;
    logic        z;
    logic        ir;
    logic        dr;
    logic        chk;
    logic [12:0] exp;
    string       name;
  } vec_t;

  vec_t  q[$];
  int    total = 0;
  int    bad   = 0;
  longint m_cyc = 0;
  longint m_ins = 0;

  logic [5:0] g_op;
  logic [1:0] g_rw, g_br;
  logic       g_mr, g_mw, g_z;

  function automatic vec_t mk(input logic st, input logic [5:0] op, input logic [1:0] rw,
                              input logic mr, input logic mw, input logic [1:0] br,
                              input logic z, input logic ir, input logic dr,
                              input logic [12:0] e, input string nm);
    vec_t v;
    v.rst = 1'b0; v.start = st; v.op = op; v.rw = rw; v.mr = mr; v.mw = mw;
    v.br = br; v.z = z; v.ir = ir; v.dr = dr; v.chk = 1'b1; v.exp = e; v.name = nm;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic set_instr(input logic [5:0] op, input logic [1:0] rw, input logic mr,
                           input logic mw, input logic [1:0] br, input logic z);
    g_op = op; g_rw = rw; g_mr = mr; g_mw = mw; g_br = br; g_z = z;
  endtask

  task automatic push(input logic r, input logic st, input logic ir, input logic dr,
                      input logic chk, input logic [12:0] e, input string nm);
    vec_t v;
    v = mk(st, g_op, g_rw, g_mr, g_mw, g_br, g_z, ir, dr, e, nm);
    v.rst = r;
    v.chk = chk;
    q.push_back(v);
  endtask

  task automatic run_q();
    foreach (q[i]) begin
      @(negedge clk);
      rst = q[i].rst; start = q[i].start; opcode = q[i].op; reg_write = q[i].rw;
      mem_read = q[i].mr; mem_write = q[i].mw; branch = q[i].br; zero_flag = q[i].z;
      imem_ready = q[i].ir; dmem_ready = q[i].dr;
      #1;
      if (q[i].chk) begin
        total++;
        if (act !== q[i].exp) begin
          bad++;
          $display("FAIL %s step=%0d got=%h want=%h", q[i].name, i, act, q[i].exp);
        end
      end
      if (q[i].rst) begin
        m_cyc = 0;
        m_ins = 0;
      end else begin
        if (q[i].exp[2]) m_cyc++;
        if (q[i].exp[4]) m_ins++;
      end
    end
    q.delete();
  endtask

  task automatic check_perf(input string nm);
`ifdef PERF_CNT_EN
    total++;
    if (cycle_cnt !== 32'(m_cyc)) begin
      bad++;
      $display("FAIL %s_cycle_cnt got=%0d want=%0d", nm, cycle_cnt, m_cyc);
    end
    total++;
    if (instr_cnt !== 32'(m_ins)) begin
      bad++;
      $display("FAIL %s_instr_cnt got=%0d want=%0d", nm, instr_cnt, m_ins);
    end
`else
    if (nm.len() < 0) $display("%s", nm);
`endif
  endtask

  task automatic do_reset();
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, "rst");
    push(1'b0, 1'b0, rb(), rb(), 1'b1, 13'h0, "idle");
  endtask

  task automatic do_start();
    push(1'b0, 1'b1, rb(), rb(), 1'b1, 13'h0, "idle_start");
  endtask

  // Expected trace of one instruction; st returns 0 retired, 1 halted, 2 faulted.
  task automatic gen_instr(input int fw, input int mwt, output int st);
    logic        taken;
    logic [12:0] mem_e;
    st = 0;
    if (TO != 8'd0 && fw >= int'(TO)) begin
      for (int i = 0; i < int'(TO); i++) push(1'b0, rb(), 1'b0, rb(), 1'b1, O_IMEM | O_BUSY, "fetch_wait_to");
      push(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, O_FAULT, "fetch_fault");
      push(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, O_FAULT, "fault_hold");
      st = 2;
      return;
    end
    for (int i = 0; i < fw; i++) push(1'b0, rb(), 1'b0, rb(), 1'b1, O_IMEM | O_BUSY, "fetch_wait");
    push(1'b0, rb(), 1'b1, rb(), 1'b1, O_IMEM | O_IRL | O_BUSY, "fetch_rdy");
    push(1'b0, rb(), rb(), rb(), 1'b1, O_BUSY, "decode");
    if (g_op == 6'h3F) begin
      push(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, O_HALT, "halt");
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, O_HALT, "halt_hold");
      st = 1;
      return;
    end
    case (g_br)
      2'b01:   taken = 1'b1;
      2'b10:   taken = g_z;
      2'b11:   taken = !g_z;
      default: taken = 1'b0;
    endcase
    if (g_br != 2'b00) begin
      push(1'b0, rb(), rb(), rb(), 1'b1, O_ALU | O_PCL | (taken ? O_PCS : 13'h0) | O_BUSY, "exec_br");
    end else if (g_mr || g_mw) begin
      push(1'b0, rb(), rb(), rb(), 1'b1, O_ALU | O_BUSY, "exec_mem");
      mem_e = O_DREQ | (g_mw ? O_DWE : 13'h0) | O_BUSY;
      if (TO != 8'd0 && mwt >= int'(TO)) begin
        for (int i = 0; i < int'(TO); i++) push(1'b0, rb(), rb(), 1'b0, 1'b1, mem_e, "mem_wait_to");
        push(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, O_FAULT, "mem_fault");
        push(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, O_FAULT, "fault_hold");
        st = 2;
        return;
      end
      for (int i = 0; i < mwt; i++) push(1'b0, rb(), rb(), 1'b0, 1'b1, mem_e, "mem_wait");
      if (g_mr) begin
        push(1'b0, rb(), rb(), 1'b1, 1'b1, mem_e, "mem_rdy_ld");
        push(1'b0, rb(), rb(), rb(), 1'b1, O_RFWE | o_sel(g_rw) | O_PCL | O_BUSY, "wb_ld");
      end else begin
        push(1'b0, rb(), rb(), 1'b1, 1'b1, mem_e | O_PCL, "mem_rdy_st");
      end
    end else if (g_rw != 2'b00) begin
      push(1'b0, rb(), rb(), rb(), 1'b1, O_ALU | O_BUSY, "exec_alu_wb");
      push(1'b0, rb(), rb(), rb(), 1'b1, O_RFWE | o_sel(g_rw) | O_PCL | O_BUSY, "wb");
    end else begin
      push(1'b0, rb(), rb(), rb(), 1'b1, O_ALU | O_PCL | O_BUSY, "exec_nop");
    end
  endtask

  vec_t alu_tab[6];

  initial begin
    int st;
    int fw, mwt;
    rst = 1'b1; start = 1'b0; opcode = 6'h0; reg_write = 2'b0; mem_read = 1'b0;
    mem_write = 1'b0; branch = 2'b0; zero_flag = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    set_instr(6'h00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);

    alu_tab[0] = mk(1'b1, 6'h01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 13'h0, "alu_idle");
    alu_tab[1] = mk(1'b0, 6'h01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, O_IMEM | O_IRL | O_BUSY, "alu_fetch");
    alu_tab[2] = mk(1'b0, 6'h01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, O_BUSY, "alu_decode");
    alu_tab[3] = mk(1'b0, 6'h01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, O_ALU | O_BUSY, "alu_exec");
    alu_tab[4] = mk(1'b0, 6'h01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
                    O_RFWE | o_sel(2'b01) | O_PCL | O_BUSY, "alu_wb");
    alu_tab[5] = mk(1'b0, 6'h01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, O_IMEM | O_BUSY, "alu_refetch");

    do_reset();
    run_q();
    for (int i = 0; i < 6; i++) q.push_back(alu_tab[i]);
    run_q();

    // Reset while a store waits in MEM, then restart.
    do_reset();
    set_instr(6'h2B, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    do_start();
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_IMEM | O_IRL | O_BUSY, "st_fetch");
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_BUSY, "st_decode");
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_ALU | O_BUSY, "st_exec");
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_DREQ | O_DWE | O_BUSY, "st_mem_wait");
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, "rst_mid_mem");
    push(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 13'h0, "post_rst_idle");
    push(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 13'h0, "post_rst_start");
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_IMEM | O_BUSY, "resume_fetch");
    run_q();

    // Load with two wait states, conditional branches, then a fetch timeout.
    do_reset();
    do_start();
    set_instr(6'h23, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0);
    gen_instr(0, 2, st);
    set_instr(6'h04, 2'b01, 1'b1, 1'b0, 2'b10, 1'b0);
    gen_instr(0, 0, st);
    set_instr(6'h05, 2'b01, 1'b1, 1'b0, 2'b11, 1'b0);
    gen_instr(0, 0, st);
    set_instr(6'h06, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    gen_instr(int'(TO), 0, st);
    run_q();
    check_perf("directed_timeout");

    // Ready on the last allowed fetch cycle wins, then halt does not retire.
    do_reset();
    do_start();
    set_instr(6'h07, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
    gen_instr(int'(TO) - 1, 0, st);
    set_instr(6'h3F, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
    gen_instr(0, 0, st);
    run_q();
    check_perf("directed_halt");

    for (int p = 0; p < 40; p++) begin
      do_reset();
      do_start();
      st = 0;
      for (int n = 0; n < 15 && st == 0; n++) begin
        set_instr(($urandom_range(0, 9) == 0) ? 6'h3F : 6'($urandom_range(0, 62)),
                  2'($urandom_range(0, 3)), rb(), rb(), 2'($urandom_range(0, 3)), rb());
        if ($urandom_range(0, 1) == 0) g_br = 2'b00;
        fw  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
        mwt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
        gen_instr(fw, mwt, st);
      end
      if (st == 0) begin
        set_instr(6'h3F, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        gen_instr(0, 0, st);
      end
      run_q();
      check_perf("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
